// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, global advance
// enable, synchronous flush, optional 2-entry skid buffer and saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 0,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_head;
  logic [CNT_W-1:0]    r_stall;
  logic [DATA_W-1:0]   w_skid_data;
  logic                w_acc;
  logic                w_rel;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_head;
  assign occ       = r_state;
  assign stall_cnt = r_stall;

  // Skid mode registers in_ready; latch mode passes out_ready straight through.
  always_comb begin
    in_ready = 1'b1;
    if (SKID != 0) begin
      in_ready = (r_state != ST_TWO);
    end else begin
      in_ready = !out_valid || out_ready;
    end
  end

  assign w_acc = in_valid  && in_ready  && en && !flush;
  assign w_rel = out_valid && out_ready && en && !flush;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] r_skid;

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_skid <= '0;
        end else if (r_state == ST_ONE && w_acc && !w_rel) begin
          r_skid <= in_data;
        end
      end

      assign w_skid_data = r_skid;
    end else begin : g_noskid
      assign w_skid_data = '0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_EMPTY;
      r_head  <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_state <= ST_ONE;
            r_head  <= in_data;
          end
        end
        ST_ONE: begin
          if (w_acc && w_rel) begin
            r_head <= in_data;
          end else if (w_acc) begin
            if (SKID != 0) begin
              r_state <= ST_TWO;
            end
          end else if (w_rel) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_rel) begin
            r_state <= ST_ONE;
            r_head  <= w_skid_data;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Counts every held-valid cycle, including en=0 and flush cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall <= '0;
    end else if (out_valid && !w_rel && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the general successor to the fixed per-stage latches between datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload of any width, with a valid/ready handshake, a global advance enable that takes the place of ihit/dhit gating, a synchronous flush that inserts a bubble, and an optional 2-entry skid mode that registers `in_ready`. A saturating stall counter gives performance visibility per stage.

## Interface
Parameters:
- `DATA_W`, 32: payload width in bits; must be at least 1.
- `SKID`, 0: 0 selects a 1-entry latch; 1 selects a 2-entry skid buffer.
- `CNT_W`, 16: width of the stall counter.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `en`  in  1  global advance enable. No transfer happens on either side while `en`=0.
- `flush`  in  1  synchronous flush; discards every stored entry.
- `in_valid`  in  1  the upstream stage presents a payload.
- `in_data`  in  DATA_W  upstream payload.
- `in_ready`  out  1  the stage can accept a payload.
- `out_valid`  out  1  the head entry is valid.
- `out_data`  out  DATA_W  head payload.
- `out_ready`  in  1  the downstream stage can take the head entry.
- `occ`  out  2  number of stored entries (0..1 when SKID=0, 0..2 when SKID=1).
- `stall_cnt`  out  CNT_W  count of cycles in which the head entry was held.

## Operation
- `acc` = `in_valid` & `in_ready` & `en` & !`flush`.
- `rel` = `out_valid` & `out_ready` & `en` & !`flush`.
- The block holds entries in a FIFO of depth 1+SKID, made of a head register (H) and, when SKID=1, a skid register (S).
- `out_valid` = (state != EMPTY); `out_data` = H; `occ` = state encoding (EMPTY=0, ONE=1, TWO=2).
- `in_ready` when SKID=0: !`out_valid` | `out_ready`. This is combinational pass-through of `out_ready`, and `en` is not included.
- `in_ready` when SKID=1: (state != TWO). It depends only on registered state.
- State transitions (flush overrides all of them):
  - EMPTY: `acc` → ONE, with H←`in_data`.
  - ONE: `acc` & !`rel` → TWO, with S←`in_data` (only reachable when SKID=1).
  - ONE: `acc` & `rel` → ONE, with H←`in_data`.
  - ONE: `rel` & !`acc` → EMPTY.
  - TWO: `rel` → ONE, with H←S. `acc` cannot occur in TWO because `in_ready`=0.
  - Any state with neither `acc` nor `rel`: hold state, H and S unchanged.
- `flush`=1 sets the next state to EMPTY. An incoming payload in the same cycle is dropped and a pending release does not occur. H and S may keep stale data, but `out_valid`=0.
- `stall_cnt` increments by 1 in every cycle where `out_valid`=1 and !`rel`, which includes cycles with `en`=0 and flush cycles. It saturates at 2^CNT_W−1 and never wraps. Flush does not clear it; only reset does.
- Payload is opaque: no bit is interpreted and there is no width conversion.

## Timing
- Reset (`nRST`=0, asynchronous, effective mid-cycle): state=EMPTY, H=0, S=0, `stall_cnt`=0. Outputs during reset: `out_valid`=0, `out_data`=0, `occ`=0, `in_ready`=1.
- Latency: a payload accepted at edge k appears on `out_data` with `out_valid`=1 after edge k, so it can be released at edge k+1 at the earliest.
- Throughput: 1 payload per cycle in both modes while `en`=1 and `out_ready`=1.
- SKID=1: deassertion of `out_ready` reaches upstream `in_ready` one cycle later. The S entry absorbs the payload accepted in that gap, so nothing is lost.
- `en`=0: state is frozen, except that `stall_cnt` still increments. `in_ready` is still driven per the rules above, and upstream must treat only cycles with `en`=1 as transfers.
- Simultaneous `acc` and `rel` in ONE: the new payload replaces H in the same edge, and `occ` stays at 1.
- Order is strictly FIFO; no payload is duplicated or dropped except by flush.

## Test plan
- Reset and streaming: assert `nRST`=0 mid-cycle → all outputs read 0 with `in_ready`=1 immediately. Then with SKID=0, `en`=1, `out_ready`=1, send 0x11, 0x22, 0x33 on consecutive cycles → each appears on `out_data` one cycle after it is accepted, `occ` holds at 1, and `stall_cnt` stays 0.
- Backpressure in SKID=1: hold `out_ready`=0 while sending 0xA, 0xB → `occ` reaches 2 and `in_ready`=0 on the next cycle. Raise `out_ready` → 0xA then 0xB are released in order, `occ` goes 2→1→0, and `stall_cnt` equals the number of held-valid cycles.
- Enable gating: drive `en`=0 for 3 cycles with `in_valid`=1 and `out_ready`=1 while holding 0x5 → `out_data` stays 0x5, `occ` is unchanged, and `stall_cnt` increases by 3.
- Flush collision: with `occ`=2 (SKID=1), assert `flush` together with `in_valid`=1 (payload 0xF) and `out_ready`=1 → next cycle `occ`=0, `out_valid`=0, and 0xF never appears on `out_data`.
- Counter saturation: set CNT_W=4 and hold a valid entry with `out_ready`=0 for 20 cycles → `stall_cnt` reaches 15 and stays at 15.
- Width parameterisation: set DATA_W=1 and DATA_W=300 and stream alternating all-ones / all-zeros patterns → every bit of each payload passes through intact.
